// File: rtl/regfile_wr_arb_pkg.sv
// ============================================================================
//  Module  : regfile_wr_arb_pkg
//  Purpose : Shared CPU constants for the register-file write arbiter:
//            default datapath widths, requester indices, grant encoding and
//            a saturating counter helper.
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package regfile_wr_arb_pkg;

    // Default datapath widths (32 registers of 32 bits)
    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_ADDR_WIDTH = 5;

    // Width of the write counter
    localparam int COUNT_WIDTH = 16;

    // Requester indices: bit position in the one-hot grant vector
    localparam int REQ_ALU = 0;
    localparam int REQ_MEM = 1;

    // One-hot grant encoding, bit n set means requester n is granted
    typedef enum logic [1:0] {
        GNT_NONE = 2'b00,
        GNT_ALU  = 2'b01,
        GNT_MEM  = 2'b10
    } grant_t;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
        return (v == {COUNT_WIDTH{1'b1}}) ? v : v + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
    endfunction

endpackage : regfile_wr_arb_pkg

`default_nettype wire

// File: rtl/regfile_wr_arb_arb2_grant.sv
// ============================================================================
//  Module  : arb2_grant
//  Purpose : Two-requester combinational grant. A lone requester is granted
//            directly; on contention the pointer selects the winner.
//  Ports   : i_valid0 / i_valid1 - request lines (ALU / memory load)
//            i_ptr               - contention winner (0 = ALU, 1 = MEM)
//            o_grant             - one-hot grant, bit n = requester n
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module arb2_grant
    import regfile_wr_arb_pkg::*;
(
    input  logic       i_valid0,
    input  logic       i_valid1,
    input  logic       i_ptr,
    output logic [1:0] o_grant
);

    grant_t w_grant;

    always_comb begin
        w_grant = GNT_NONE;
        if (i_valid0 && i_valid1) begin
            w_grant = i_ptr ? GNT_MEM : GNT_ALU;
        end else if (i_valid1) begin
            w_grant = GNT_MEM;
        end else if (i_valid0) begin
            w_grant = GNT_ALU;
        end
    end

    assign o_grant = w_grant;

endmodule : arb2_grant

`default_nettype wire

// File: rtl/regfile_wr_arb.sv
// ============================================================================
//  Module  : regfile_wr_arb
//  Purpose : Arbitrates ALU and memory-load writebacks onto the single
//            register-file write port. Accepted writes appear one cycle later;
//            writes to register 0 are accepted but dropped. Counts issued
//            writes in a saturating 16-bit counter.
//  Ports   : Clk, Reset (sync, active-high)
//            Valid0/Addr0/Data0/Ready0 - ALU writeback requester
//            Valid1/Addr1/Data1/Ready1 - memory-load writeback requester
//            RegWrite/WriteRegister/WriteData - register-file write port
//            WriteCount - saturating count of issued writes
//  Config  : REGFILE_WR_ARB_RR_EN defined   -> round-robin on contention
//            REGFILE_WR_ARB_RR_EN undefined -> memory load always wins
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module regfile_wr_arb
    import regfile_wr_arb_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
)(
    input  logic                   Clk,
    input  logic                   Reset,

    input  logic                   Valid0,
    input  logic [ADDR_WIDTH-1:0]  Addr0,
    input  logic [DATA_WIDTH-1:0]  Data0,
    output logic                   Ready0,

    input  logic                   Valid1,
    input  logic [ADDR_WIDTH-1:0]  Addr1,
    input  logic [DATA_WIDTH-1:0]  Data1,
    output logic                   Ready1,

    output logic                   RegWrite,
    output logic [ADDR_WIDTH-1:0]  WriteRegister,
    output logic [DATA_WIDTH-1:0]  WriteData,
    output logic [COUNT_WIDTH-1:0] WriteCount
);

    // ------------------------------------------------------------------
    // Contention winner selection
    // ------------------------------------------------------------------
    logic w_ptr;
    logic [1:0] w_grant;
    logic [1:0] w_ready;

`ifdef REGFILE_WR_ARB_RR_EN
    // Pointer names the requester that wins the next contention. It only
    // moves on contended grants so a lone requester never disturbs fairness.
    logic w_contended;
    logic r_ptr_q;
    logic r_ptr_d;

    assign w_contended = Valid0 && Valid1 && !Reset;

    always_comb begin
        r_ptr_d = r_ptr_q;
        if (w_contended) begin
            r_ptr_d = w_grant[REQ_ALU];
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_ptr_q <= 1'b0;
        end else begin
            r_ptr_q <= r_ptr_d;
        end
    end

    assign w_ptr = r_ptr_q;
`else
    // Fixed priority: the memory load always wins contention
    assign w_ptr = 1'b1;
`endif

    arb2_grant u_arb2_grant (
        .i_valid0 (Valid0),
        .i_valid1 (Valid1),
        .i_ptr    (w_ptr),
        .o_grant  (w_grant)
    );

    // No request is accepted while reset is held
    assign w_ready = Reset ? 2'b00 : w_grant;
    assign Ready0  = w_ready[REQ_ALU];
    assign Ready1  = w_ready[REQ_MEM];

    // ------------------------------------------------------------------
    // Output stage and write counter
    // ------------------------------------------------------------------
    logic                   w_xfer;
    logic [ADDR_WIDTH-1:0]  w_sel_addr;
    logic [DATA_WIDTH-1:0]  w_sel_data;

    logic                   r_we_q;
    logic                   r_we_d;
    logic [ADDR_WIDTH-1:0]  r_waddr_q;
    logic [ADDR_WIDTH-1:0]  r_waddr_d;
    logic [DATA_WIDTH-1:0]  r_wdata_q;
    logic [DATA_WIDTH-1:0]  r_wdata_d;
    logic [COUNT_WIDTH-1:0] r_count_q;
    logic [COUNT_WIDTH-1:0] r_count_d;

    assign w_xfer     = |w_ready;
    assign w_sel_addr = w_ready[REQ_MEM] ? Addr1 : Addr0;
    assign w_sel_data = w_ready[REQ_MEM] ? Data1 : Data0;

    always_comb begin
        r_waddr_d = r_waddr_q;
        r_wdata_d = r_wdata_q;
        // Register 0 is hard-wired: the transfer completes but nothing is written
        r_we_d    = w_xfer && (w_sel_addr != '0);
        if (w_xfer) begin
            r_waddr_d = w_sel_addr;
            r_wdata_d = w_sel_data;
        end
        // Counter advances together with the write it accounts for, so it
        // already reflects a write in the same cycle RegWrite is high
        r_count_d = r_we_d ? sat_inc(r_count_q) : r_count_q;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_we_q    <= 1'b0;
            r_waddr_q <= '0;
            r_wdata_q <= '0;
            r_count_q <= '0;
        end else begin
            r_we_q    <= r_we_d;
            r_waddr_q <= r_waddr_d;
            r_wdata_q <= r_wdata_d;
            r_count_q <= r_count_d;
        end
    end

    // A write pending when reset arrives is dropped rather than issued
    assign RegWrite      = r_we_q && !Reset;
    assign WriteRegister = r_waddr_q;
    assign WriteData     = r_wdata_q;
    assign WriteCount    = r_count_q;

endmodule : regfile_wr_arb

`default_nettype wire
